pc_sequencer: RTL and testbench

//  Next-generation program counter. Width-parametrised PC with stall, absolute jump,
//  PC-relative branch, and call/return backed by a hardware return-address stack (RAS).

---
 rtl/pc_seq_pkg.sv | 32 +++
 rtl/pc_sequencer_ras.sv | 71 +++++++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// ============================================================================
//  pc_seq_pkg : shared op-select encoding and priority decode for pc_sequencer
//  Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_RET    = 3'd1,
    OP_CALL   = 3'd2,
    OP_JUMP   = 3'd3,
    OP_BRANCH = 3'd4,
    OP_INC    = 3'd5
  } op_e;

  // Fixed priority: stall > ret > call > jump > branch > sequential increment.
  function automatic op_e sel_op(input logic stall_i, input logic ret_i,
                                 input logic call_i, input logic jump_i,
                                 input logic branch_i);
    if (stall_i)       return OP_HOLD;
    else if (ret_i)    return OP_RET;
    else if (call_i)   return OP_CALL;
    else if (jump_i)   return OP_JUMP;
    else if (branch_i) return OP_BRANCH;
    else               return OP_INC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_ras.sv
// ============================================================================
//  ret_addr_stack : circular return-address LIFO, overwrite-oldest when full,
//                   pop when empty is ignored. Registered full/empty flags.
//  Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module ret_addr_stack #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              w_do_pop;

  assign w_do_pop = pop_i && !push_i && (count_q != '0);

  // Write pointer wraps, so a push on a full stack lands on the oldest slot.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (count_q != C_DEPTH) count_d = count_q + CNT_W'(1);
    end else if (w_do_pop) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      full_q  <= (count_d == C_DEPTH);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_i) mem_q[ptr_q] <= push_data_i;
  end

  assign top_o   = mem_q[ptr_q - PTR_W'(1)];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  pc_sequencer : fetch-stage program counter with stall, jump, relative
//                 branch and call/return through a return-address stack.
//  Option       : define PC_SEQ_RAS_ERR_EN to add the sticky ras_err output.
//  Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned INC        = 1,
  parameter int unsigned OFF_W      = 8,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_en,
  input  logic              branch_en,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [ADDR_W-1:0] tgt_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ras_empty,
  output logic              ras_full
`ifdef PC_SEQ_RAS_ERR_EN
  ,
  output logic              ras_err
`endif
);

  localparam logic [ADDR_W-1:0] C_INC   = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] C_RESET = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] w_pc_inc, w_off_sx, w_ras_top;
  logic              w_push, w_pop;
  op_e               w_op;

  assign w_op     = sel_op(stall, ret_en, call_en, jump_en, branch_en);
  assign w_pc_inc = pc_q + C_INC;
  assign w_off_sx = ADDR_W'($signed(branch_off));

  always_comb begin
    pc_d   = w_pc_inc;
    w_push = 1'b0;
    w_pop  = 1'b0;
    unique case (w_op)
      OP_HOLD:   pc_d = pc_q;
      OP_RET: begin
        // Underflow falls through to a plain increment.
        if (!ras_empty) begin
          pc_d  = w_ras_top;
          w_pop = 1'b1;
        end
      end
      OP_CALL: begin
        pc_d   = tgt_addr;
        w_push = 1'b1;
      end
      OP_JUMP:   pc_d = tgt_addr;
      OP_BRANCH: pc_d = pc_q + w_off_sx;
      default:   pc_d = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= C_RESET;
    else       pc_q <= pc_d;
  end

  ret_addr_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_data_i (w_pc_inc),
    .top_o       (w_ras_top),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

  assign pc_out = pc_q;

`ifdef PC_SEQ_RAS_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if ((w_op == OP_CALL && ras_full) || (w_op == OP_RET && ras_empty))
      err_q <= 1'b1;
  end

  assign ras_err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  tb_pc_sequencer : directed scenarios plus randomized run against a
//                    queue-based reference model of the PC and return stack.
//  Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, stall, jump_en, branch_en, call_en, ret_en;
  logic [7:0] branch_off, tgt_addr;
  logic [7:0] pc_out;
  logic       ras_empty, ras_full;
`ifdef PC_SEQ_RAS_ERR_EN
  logic       ras_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_pc;
  logic [7:0] m_ras[$];
  bit         m_err;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(8), .RESET_ADDR(32'h10), .INC(1), .OFF_W(8), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump_en(jump_en),
    .branch_en(branch_en), .branch_off(branch_off), .call_en(call_en),
    .ret_en(ret_en), .tgt_addr(tgt_addr), .pc_out(pc_out),
    .ras_empty(ras_empty), .ras_full(ras_full)
`ifdef PC_SEQ_RAS_ERR_EN
    , .ras_err(ras_err)
`endif
  );

  task automatic model_step();
    logic signed [7:0] so;
    so = branch_off;
    if (reset) begin
      m_pc = 'h10; m_ras.delete(); m_err = 0;
    end else if (stall) begin
    end else if (ret_en) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = (m_pc + 1) & 255; m_err = 1; end
    end else if (call_en) begin
      if (m_ras.size() == DEPTH) begin void'(m_ras.pop_front()); m_err = 1; end
      m_ras.push_back(8'((m_pc + 1) & 255));
      m_pc = tgt_addr;
    end else if (jump_en) m_pc = tgt_addr;
    else if (branch_en) m_pc = (m_pc + int'(so)) & 255;
    else m_pc = (m_pc + 1) & 255;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; jump_en = 0; branch_en = 0; call_en = 0; ret_en = 0;
    branch_off = '0; tgt_addr = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_jump(input logic [7:0] a);
    jump_en = 1; tgt_addr = a; tick();
  endtask

  task automatic do_call(input logic [7:0] a);
    call_en = 1; tgt_addr = a; tick();
  endtask

  task automatic test_reset();
    logic [7:0] exp_pc[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    reset = 1; tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pc_out !== exp_pc[i] || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_seq[%0d]: pc=%h empty=%b full=%b, required pc=%h empty=1 full=0",
                 i, pc_out, ras_empty, ras_full, exp_pc[i]);
      end
      if (i < 3) tick();
    end
`ifdef PC_SEQ_RAS_ERR_EN
    n_checks++;
    if (ras_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_err: ras_err=%b, required 0", ras_err);
    end
`endif
  endtask

  task automatic test_wrap_branch();
    logic [7:0] exp_pc[3] = '{8'hFF, 8'h00, 8'h01};
    do_jump(8'hFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc_out !== exp_pc[i]) begin
        n_errors++; $display("FAIL wrap[%0d]: pc=%h, required %h", i, pc_out, exp_pc[i]);
      end
    end
    do_jump(8'h05);
    branch_en = 1; branch_off = 8'hFA; tick();
    n_checks++;
    if (pc_out !== 8'hFF) begin
      n_errors++; $display("FAIL branch_neg: pc=%h, required ff", pc_out);
    end
    branch_en = 1; branch_off = 8'h07; tick();
    n_checks++;
    if (pc_out !== 8'h06) begin
      n_errors++; $display("FAIL branch_pos_wrap: pc=%h, required 06", pc_out);
    end
  endtask

  task automatic test_call_ret();
    do_jump(8'h20);
    do_call(8'h80);
    n_checks++;
    if (pc_out !== 8'h80 || ras_empty !== 1'b0) begin
      n_errors++; $display("FAIL call: pc=%h empty=%b, required pc=80 empty=0", pc_out, ras_empty);
    end
    tick(); tick();
    n_checks++;
    if (pc_out !== 8'h82) begin
      n_errors++; $display("FAIL call_idle: pc=%h, required 82", pc_out);
    end
    ret_en = 1; tick();
    n_checks++;
    if (pc_out !== 8'h21 || ras_empty !== 1'b1) begin
      n_errors++; $display("FAIL ret: pc=%h empty=%b, required pc=21 empty=1", pc_out, ras_empty);
    end
  endtask

  task automatic test_nested_overflow();
    logic [7:0] exp_pop[5] = '{8'h71, 8'h61, 8'h51, 8'h41, 8'h42};
    reset = 1; tick();
    do_jump(8'h30);
    for (int i = 1; i <= 5; i++) do_call(8'((i + 3) * 16));
    n_checks++;
    if (ras_full !== 1'b1 || pc_out !== 8'h80) begin
      n_errors++; $display("FAIL nest_full: full=%b pc=%h, required full=1 pc=80", ras_full, pc_out);
    end
    for (int i = 0; i < 5; i++) begin
      ret_en = 1; tick();
      n_checks++;
      if (pc_out !== exp_pop[i]) begin
        n_errors++; $display("FAIL nest_ret[%0d]: pc=%h, required %h", i, pc_out, exp_pop[i]);
      end
    end
    n_checks++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      n_errors++; $display("FAIL nest_empty: empty=%b full=%b, required 1/0", ras_empty, ras_full);
    end
`ifdef PC_SEQ_RAS_ERR_EN
    n_checks++;
    if (ras_err !== 1'b1) begin
      n_errors++; $display("FAIL nest_err: ras_err=%b, required 1", ras_err);
    end
`endif
  endtask

  task automatic test_priority();
    do_jump(8'h43);
    do_call(8'h99);
    ret_en = 1; call_en = 1; jump_en = 1; tgt_addr = 8'hAA; tick();
    n_checks++;
    if (pc_out !== 8'h44 || ras_empty !== 1'b1) begin
      n_errors++; $display("FAIL prio_ret: pc=%h empty=%b, required pc=44 empty=1", pc_out, ras_empty);
    end
    stall = 1; jump_en = 1; ret_en = 1; tgt_addr = 8'h55; tick();
    n_checks++;
    if (pc_out !== 8'h44 || ras_empty !== 1'b1) begin
      n_errors++; $display("FAIL prio_stall: pc=%h empty=%b, required pc=44 empty=1", pc_out, ras_empty);
    end
  endtask

  task automatic test_reset_call();
    do_call(8'h33);
    reset = 1; call_en = 1; tgt_addr = 8'h90; tick();
    n_checks++;
    if (pc_out !== 8'h10 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_call: pc=%h empty=%b full=%b, required pc=10 empty=1 full=0",
               pc_out, ras_empty, ras_full);
    end
`ifdef PC_SEQ_RAS_ERR_EN
    n_checks++;
    if (ras_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_call_err: ras_err=%b, required 0", ras_err);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      stall      = ($urandom_range(0, 7) == 0);
      ret_en     = ($urandom_range(0, 3) == 0);
      call_en    = ($urandom_range(0, 2) == 0);
      jump_en    = ($urandom_range(0, 5) == 0);
      branch_en  = ($urandom_range(0, 2) == 0);
      branch_off = 8'($urandom);
      tgt_addr   = 8'($urandom);
      tick();
      n_checks++;
      if (pc_out !== 8'(m_pc) || ras_empty !== (m_ras.size() == 0) ||
          ras_full !== (m_ras.size() == DEPTH)) begin
        n_errors++;
        $display("FAIL random[%0d]: pc=%h empty=%b full=%b, required pc=%h empty=%b full=%b",
                 i, pc_out, ras_empty, ras_full, 8'(m_pc), m_ras.size() == 0,
                 m_ras.size() == DEPTH);
      end
`ifdef PC_SEQ_RAS_ERR_EN
      n_checks++;
      if (ras_err !== m_err) begin
        n_errors++; $display("FAIL random_err[%0d]: ras_err=%b, required %b", i, ras_err, m_err);
      end
`endif
    end
  endtask

  initial begin
    m_pc = 'h10; m_err = 0;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    test_reset();
    test_wrap_branch();
    test_call_ret();
    test_nested_overflow();
    test_priority();
    test_reset_call();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
